i2c_slave_core: RTL and testbench



---
 rtl/i2c_slave_core.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_i2c_slave_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_core.sv
// ---------------------------------------------------------------------------
// i2c_slave_core
// I2C target responder. SCL/SDA are oversampled on clk, START / repeated
// START / STOP are detected, a 7-bit address is matched and ACKed, received
// bytes are handed to local logic, and (optionally) master-read bytes are
// served. SDA is open-drain style: sda_o = 0 pulls low, 1 releases.
//
// Optional feature macro: I2C_SLAVE_READ_EN
//   defined   : master-read path (TX_DATA / TX_ACK, tx_req) is built.
//   undefined : address with R/W=1 is NACKed, tx_req tied 0, tx_data unused.
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   enable            1 = respond to bus, 0 = never ACK, stay in IDLE
//   scl_i, sda_i      asynchronous bus inputs
//   sda_o             SDA drive (0 = pull low, 1 = release)
//   rx_data/rx_valid  last received data byte / 1-cycle update pulse
//   tx_data/tx_req    byte to send on master read / 1-cycle latch pulse
//   busy              1 while addressed
//   stop_det          1-cycle pulse on every STOP
// ---------------------------------------------------------------------------
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h6B,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_DATA, S_RX_ACK, S_WAIT_STOP
`ifdef I2C_SLAVE_READ_EN
    , S_TX_DATA, S_TX_ACK
`endif
  } state_t;

  // ---------------- synchronizer + history ----------------
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  // The synchronizer resets to 1 (idle bus) so reset release never looks
  // like an SDA/SCL falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high in both samples: an SDA edge coinciding with an SCL
  // edge is a data change during SCL low, not a bus condition.
  assign w_start    = w_scl & r_scl_d &  r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d &  w_sda;

  // ---------------- FSM state and datapath registers ----------------
  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt, w_shift_in;
  logic       r_done, w_done_nxt;   // 8th rise of the current byte seen
  logic       r_sda_o, w_sda_o_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_stop_det, w_stop_det_nxt;
  logic       w_addr_ok;

  assign w_shift_in = {r_shift[6:0], w_sda};

`ifdef I2C_SLAVE_READ_EN
  logic [7:0] r_tx, w_tx_nxt;
  logic       r_tx_req, w_tx_req_nxt;
  assign w_addr_ok = (r_shift[7:1] == SLAVE_ADDR);
`else
  // Without the read path, R/W=1 is not a permitted direction.
  assign w_addr_ok = (r_shift[7:1] == SLAVE_ADDR) && !r_shift[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd7;
      r_shift    <= '0;
      r_done     <= 1'b0;
      r_sda_o    <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_stop_det <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      r_tx       <= '0;
      r_tx_req   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_done     <= w_done_nxt;
      r_sda_o    <= w_sda_o_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_stop_det <= w_stop_det_nxt;
`ifdef I2C_SLAVE_READ_EN
      r_tx       <= w_tx_nxt;
      r_tx_req   <= w_tx_req_nxt;
`endif
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case below can leave a value unassigned (no latches).
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_done_nxt     = r_done;
    w_sda_o_nxt    = r_sda_o;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_stop_det_nxt = 1'b0;
`ifdef I2C_SLAVE_READ_EN
    w_tx_nxt       = r_tx;
    w_tx_req_nxt   = 1'b0;
`endif

    if (w_stop) begin
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = 3'd7;
      w_done_nxt     = 1'b0;
      w_sda_o_nxt    = 1'b1;
      w_busy_nxt     = 1'b0;
      w_stop_det_nxt = 1'b1;
    end else if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 3'd7;
      w_done_nxt  = 1'b0;
      w_sda_o_nxt = 1'b1;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
      w_cnt_nxt   = 3'd7;
      w_done_nxt  = 1'b0;
      w_sda_o_nxt = 1'b1;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            if (r_cnt == 3'd0) w_done_nxt = 1'b1;
            else               w_cnt_nxt  = r_cnt - 3'd1;
          end else if (w_scl_fall && r_done) begin
            w_done_nxt = 1'b0;
            w_cnt_nxt  = 3'd7;
            if (w_addr_ok) begin
              w_sda_o_nxt = 1'b0;
              w_busy_nxt  = 1'b1;
              w_state_nxt = S_ADDR_ACK;
            end else begin
              w_sda_o_nxt = 1'b1;
              w_state_nxt = S_WAIT_STOP;
            end
          end
        end
        // r_shift[0] still holds R/W: nothing shifts during the ACK clock.
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt = 3'd7;
`ifdef I2C_SLAVE_READ_EN
            if (r_shift[0]) begin
              w_tx_nxt     = tx_data;
              w_tx_req_nxt = 1'b1;
              w_sda_o_nxt  = tx_data[7];
              w_state_nxt  = S_TX_DATA;
            end else
`endif
            begin
              w_sda_o_nxt = 1'b1;
              w_state_nxt = S_RX_DATA;
            end
          end
        end
        S_RX_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            if (r_cnt == 3'd0) begin
              w_rx_data_nxt  = w_shift_in;
              w_rx_valid_nxt = 1'b1;
              w_done_nxt     = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - 3'd1;
            end
          end else if (w_scl_fall && r_done) begin
            w_done_nxt  = 1'b0;
            w_sda_o_nxt = 1'b0;
            w_state_nxt = S_RX_ACK;
          end
        end
        S_RX_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt   = 3'd7;
            w_sda_o_nxt = 1'b1;
            w_state_nxt = S_RX_DATA;
          end
        end
`ifdef I2C_SLAVE_READ_EN
        // r_tx is shifted left on each fall so the next bit is always r_tx[6].
        S_TX_DATA: begin
          if (w_scl_fall) begin
            if (r_cnt == 3'd0) begin
              w_sda_o_nxt = 1'b1;
              w_state_nxt = S_TX_ACK;
            end else begin
              w_cnt_nxt   = r_cnt - 3'd1;
              w_sda_o_nxt = r_tx[6];
              w_tx_nxt    = {r_tx[6:0], 1'b0};
            end
          end
        end
        S_TX_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) w_state_nxt = S_WAIT_STOP;
            else       w_done_nxt  = 1'b1;
          end else if (w_scl_fall && r_done) begin
            w_done_nxt   = 1'b0;
            w_cnt_nxt    = 3'd7;
            w_tx_nxt     = tx_data;
            w_tx_req_nxt = 1'b1;
            w_sda_o_nxt  = tx_data[7];
            w_state_nxt  = S_TX_DATA;
          end
        end
`endif
        default: ;  // IDLE / WAIT_STOP: released, only START/STOP matter
      endcase
    end
  end

  assign sda_o    = r_sda_o;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign stop_det = r_stop_det;

`ifdef I2C_SLAVE_READ_EN
  assign tx_req = r_tx_req;
`else
  logic w_unused_tx;
  assign w_unused_tx = ^tx_data;
  assign tx_req      = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_core.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_core
// Bit-banged I2C master drives a wired-AND SDA bus against i2c_slave_core.
// Expected DUT output events (rx_valid with data, tx_req, stop_det) are
// queued when each transaction is issued; a monitor pops and compares them
// as the DUT presents them. ACK bits, read data and busy are checked inline.
// ---------------------------------------------------------------------------
module tb_i2c_slave_core;

  localparam int H = 8;  // SCL half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_o;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       busy;
  logic       stop_det;
  logic       bus_sda;
  logic       saw_low = 1'b0;

  assign bus_sda = m_sda & sda_o;

  i2c_slave_core #(.SLAVE_ADDR(7'h6B), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .scl_i    (scl),
    .sda_i    (bus_sda),
    .sda_o    (sda_o),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy),
    .stop_det (stop_det)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  localparam logic [1:0] EV_RX = 2'd1, EV_TX = 2'd2, EV_STOP = 2'd3;
  logic [9:0] sb_q[$];

  task automatic sb_push(input logic [1:0] kind, input logic [7:0] data);
    sb_q.push_back({kind, data});
  endtask

  task automatic sb_pop(input logic [9:0] act);
    logic [9:0] exp;
    if (sb_q.size() == 0) begin
      check("unexpected_event", {22'd0, act}, 32'h3FF);
    end else begin
      exp = sb_q.pop_front();
      check("event", {22'd0, act}, {22'd0, exp});
    end
  endtask

  always @(negedge clk) begin
    if (!sda_o) saw_low = 1'b1;
    if (rst_n) begin
      if (rx_valid && tx_req) check("rx_tx_overlap", 32'd1, 32'd0);
      if (rx_valid) sb_pop({EV_RX, rx_data});
      if (tx_req)   sb_pop({EV_TX, 8'h00});
      if (stop_det) sb_pop({EV_STOP, 8'h00});
    end
  end

  // ---------------- bus master ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      m_sda = 1'b1; wait_clks(H);
      scl = 1'b1;   wait_clks(H);
    end
    m_sda = 1'b0; wait_clks(H);
    scl = 1'b0;   wait_clks(2);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clks(H);
    scl = 1'b1;   wait_clks(H);
    m_sda = 1'b1; wait_clks(H);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;  wait_clks(H);
    scl = 1'b1; wait_clks(H);
    scl = 1'b0; wait_clks(2);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_clks(H);
    scl = 1'b1;   wait_clks(H/2);
    b = bus_sda;  wait_clks(H/2);
    scl = 1'b0;   wait_clks(2);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    logic       ack;
    logic [7:0] rd;
    logic [7:0] addr_w;

    wait_clks(5);
    check("rst_sda_o",    {31'd0, sda_o},    32'd1);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_stop_det", {31'd0, stop_det}, 32'd0);
    check("rst_tx_req",   {31'd0, tx_req},   32'd0);
    check("rst_rx_data",  {24'd0, rx_data},  32'd0);
    rst_n = 1'b1;
    wait_clks(5);

    // Write: 0xD6, 0xA5
    sb_push(EV_RX, 8'hA5); sb_push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'hD6, ack);  check("wr_addr_ack", {31'd0, ack}, 32'd0);
    check("wr_busy", {31'd0, busy}, 32'd1);
    write_byte(8'hA5, ack);  check("wr_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    check("wr_busy_end", {31'd0, busy}, 32'd0);
    check("wr_rx_data",  {24'd0, rx_data}, 32'hA5);

    // Mismatch: 0xA0, 0x55
    saw_low = 1'b0;
    sb_push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'hA0, ack);  check("mm_addr_nack", {31'd0, ack}, 32'd1);
    check("mm_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h55, ack);  check("mm_data_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("mm_sda_released", {31'd0, saw_low}, 32'd0);

    // Disabled target never ACKs
    enable = 1'b0;
    sb_push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'hD6, ack);  check("dis_addr_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    enable = 1'b1;

    // Repeated START after 3 data bits
    sb_push(EV_RX, 8'h5A); sb_push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'hD6, ack);  check("rs_addr1_ack", {31'd0, ack}, 32'd0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    i2c_start();
    check("rs_busy_cleared", {31'd0, busy}, 32'd0);
    write_byte(8'hD6, ack);  check("rs_addr2_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h5A, ack);  check("rs_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop();

    // Async reset during ADDR_ACK
    i2c_start();
    addr_w = 8'hD6;
    for (int i = 7; i >= 0; i--) write_bit(addr_w[i]);
    m_sda = 1'b1; wait_clks(H);
    scl = 1'b1;   wait_clks(H/2);
    check("ar_pre_sda_o", {31'd0, sda_o}, 32'd0);
    check("ar_pre_busy",  {31'd0, busy},  32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_sda_o",   {31'd0, sda_o},   32'd1);
    check("ar_busy",    {31'd0, busy},    32'd0);
    check("ar_rx_data", {24'd0, rx_data}, 32'd0);
    check("ar_rx_valid",{31'd0, rx_valid},32'd0);
    wait_clks(H/2);
    scl = 1'b0; wait_clks(4);
    rst_n = 1'b1; wait_clks(4);
    sb_push(EV_RX, 8'h11); sb_push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'hD6, ack);  check("ar_post_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h11, ack);  check("ar_post_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop();

`ifdef I2C_SLAVE_READ_EN
    // Read: 0x3C (master ACK), 0xC3 (master NACK)
    tx_data = 8'h3C;
    sb_push(EV_TX, 8'h00); sb_push(EV_TX, 8'h00); sb_push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'hD7, ack);  check("rd_addr_ack", {31'd0, ack}, 32'd0);
    check("rd_busy", {31'd0, busy}, 32'd1);
    read_bit(ack); rd[7] = ack;
    tx_data = 8'hC3;
    for (int i = 6; i >= 0; i--) begin
      read_bit(ack); rd[i] = ack;
    end
    check("rd_byte0", {24'd0, rd}, 32'h3C);
    write_bit(1'b0);
    read_byte(rd);
    check("rd_byte1", {24'd0, rd}, 32'hC3);
    write_bit(1'b1);
    i2c_stop();
    check("rd_busy_end", {31'd0, busy}, 32'd0);
`else
    // Read request without read support: NACK, no tx_req
    saw_low = 1'b0;
    sb_push(EV_STOP, 8'h00);
    i2c_start();
    write_byte(8'hD7, ack);  check("nord_addr_nack", {31'd0, ack}, 32'd1);
    check("nord_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    check("nord_sda_released", {31'd0, saw_low}, 32'd0);
`endif

    wait_clks(10);
    check("sb_leftover", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
